// File: rtl/div_radix2_seq.sv
// div_radix2_seq: multi-cycle restoring divider (1 quotient bit/cycle), signed/unsigned, returns {remainder, quotient}
module div_radix2_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] rem, rem_n, quo, quo_n, dvs, dvs_n;
  logic neg_q, neg_q_n, neg_r, neg_r_n, ready_n;
  logic [2*DATA_W-1:0] result_n;
  logic [DATA_W:0] tmp;
  logic [DATA_W-1:0] sub, abs1, abs2, quo_fix, rem_fix;
  logic lt;
  assign tmp     = {rem, quo[DATA_W-1]};
  assign lt      = tmp < {1'b0, dvs};
  assign sub     = tmp[DATA_W-1:0] - dvs;
  assign abs1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign quo_fix = neg_q ? -quo : quo;
  assign rem_fix = neg_r ? -rem : rem;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    quo_n    = quo;
    dvs_n    = dvs;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    ready_n  = ready_o;
    result_n = result_o;
    case (state)
      FREE: begin
        ready_n  = 1'b0;
        result_n = '0;
        if (start_i && !annul_i) begin
          state_n = (opdata2_i == '0) ? BYZERO : ON;
          cnt_n   = '0;
          rem_n   = '0;
          quo_n   = abs1;
          dvs_n   = abs2;
          neg_q_n = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_r_n = signed_div_i && opdata1_i[DATA_W-1];
        end
      end
      BYZERO: begin
        state_n = annul_i ? FREE : END;
        quo_n   = '0;
        rem_n   = '0;
      end
      ON: begin
        if (annul_i) state_n = FREE;
        else begin
          rem_n   = lt ? tmp[DATA_W-1:0] : sub;
          quo_n   = {quo[DATA_W-2:0], ~lt};
          cnt_n   = cnt + 1'b1;
          state_n = (cnt == CNT_W'(DATA_W - 1)) ? END : ON;
        end
      end
      default: begin
        state_n  = start_i ? END : FREE;
        ready_n  = start_i;
        result_n = start_i ? {rem_fix, quo_fix} : '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      quo      <= quo_n;
      dvs      <= dvs_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      ready_o  <= ready_n;
      result_o <= result_n;
    end
  end
endmodule

// File: tb/tb_div_radix2_seq.sv
// tb_div_radix2_seq: scoreboard bench for the sequential radix-2 divider
module tb_div_radix2_seq;
  logic clk = 0, rst = 0, signed_div_i = 0, start_i = 0, annul_i = 0;
  logic [31:0] opdata1_i = 0, opdata2_i = 0;
  logic [63:0] result_o;
  logic ready_o;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp;
  int n_checks = 0, n_fail = 0;

  div_radix2_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int n;
    exp_q.push_back(model(sgn, a, b));
    signed_div_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1;
    @(posedge clk); #1;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), (b == 0) ? 64'd2 : 64'd33);
    last_exp = exp_q.pop_front();
    check("result", result_o, last_exp);
  endtask

  task automatic release_start();
    start_i = 0;
    @(posedge clk); #1;
    check("ready_clear", {63'h0, ready_o}, 64'h0);
    check("result_clear", result_o, 64'h0);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int hits = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (ready_o) hits++;
    end
    check(tag, 64'(hits), 64'h0);
  endtask

  initial begin
    int k;
    #2 rst = 1;
    #1;
    check("reset_ready", {63'h0, ready_o}, 64'h0);
    check("reset_result", result_o, 64'h0);
    repeat (2) @(posedge clk);
    #3 rst = 0;
    @(posedge clk); #1;

    run_div(0, 32'd7, 32'd2);                     release_start();
    run_div(1, 32'hFFFFFFF9, 32'd2);              release_start();
    run_div(1, 32'h80000000, 32'hFFFFFFFF);       release_start();
    run_div(0, 32'h80000000, 32'hFFFFFFFF);       release_start();
    run_div(0, 32'd5, 32'd0);                     release_start();
    run_div(1, 32'hFFFFFFF9, 32'd0);              release_start();
    run_div(1, 32'd7, 32'hFFFFFFFE);              release_start();
    run_div(0, 32'hFFFFFFFF, 32'd1);              release_start();
    for (k = 0; k < 6; k++) begin
      run_div(1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 70000) ^ ((k % 2) ? 32'hFFFF0000 : 32'h0));
      release_start();
    end

    // abort at iteration 10 then restart
    signed_div_i = 0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 annul_i = 1; start_i = 0;
    @(posedge clk); #1 annul_i = 0;
    idle_check("annul_no_ready", 40);
    run_div(0, 32'd100, 32'd7);
    check("restart_result", result_o, {32'h2, 32'hE});
    release_start();

    // async reset mid-ON
    signed_div_i = 0; opdata1_i = 32'd12345; opdata2_i = 32'd17; start_i = 1;
    repeat (15) @(posedge clk);
    #3 rst = 1;
    #1;
    check("rst_on_ready", {63'h0, ready_o}, 64'h0);
    check("rst_on_result", result_o, 64'h0);
    start_i = 0;
    #3 rst = 0;
    idle_check("rst_on_idle", 40);

    // hold start in END, then async reset while result is valid
    run_div(1, 32'hFFFFFF00, 32'd7);
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_result", result_o, last_exp);
      check("hold_ready", {63'h0, ready_o}, 64'h1);
    end
    release_start();
    run_div(0, 32'd99, 32'd10);
    #2 rst = 1;
    #1;
    check("rst_end_ready", {63'h0, ready_o}, 64'h0);
    check("rst_end_result", result_o, 64'h0);
    start_i = 0;
    #3 rst = 0;
    idle_check("rst_end_idle", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
